tdm_demux: RTL
==============

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter N_CH, default 4: number of time-division channels; legal range 2..16.
REQ-002 Parameter W, default 8: data width per beat.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  the input beat is present this cycle.
REQ-005 in_sof  input  1  start of frame; the beat carries channel 0; qualified by in_valid.
REQ-006 in_data  input  W  the input beat payload.
REQ-007 out_data  output  N_CH x W  registered per-channel holding registers.
REQ-008 out_valid  output  N_CH  one-cycle pulse per channel when that channel's register updates.
REQ-009 frame_done  output  1  one-cycle pulse when the channel N_CH-1 beat of a locked frame is written.
REQ-010 sync_err  output  1  one-cycle pulse when in_sof arrives while the slot counter is not 0 in LOCKED.
REQ-011 locked  output  1  high while the FSM is in LOCKED.

Function
REQ-012 FSM states: HUNT and LOCKED; the reset state is HUNT.
REQ-013 In HUNT, in_valid beats with in_sof=0 SHALL be discarded: no output changes, slot stays 0.
REQ-014 In HUNT, in_valid & in_sof: next cycle out_data[0]=in_data and out_valid[0]=1; slot becomes 1; state becomes LOCKED.
REQ-015 In LOCKED, each in_valid beat SHALL write channel slot, and out_valid[slot] SHALL pulse the next cycle; latency is exactly 1 cycle.
REQ-016 The slot counter SHALL be ceil(log2(N_CH)) bits, SHALL advance only on in_valid, and SHALL wrap from N_CH-1 to 0.
REQ-017 When the slot N_CH-1 beat is written, frame_done SHALL pulse in the same cycle as out_valid[N_CH-1].
REQ-018 In LOCKED with slot==0, in_sof=1 SHALL be accepted as normal alignment with no error.
REQ-019 In LOCKED, in_valid & in_sof with slot!=0: the beat SHALL be written to channel 0, sync_err SHALL pulse, slot SHALL become 1, and the partial frame SHALL get no frame_done.
REQ-020 In LOCKED, in_sof=0 at slot==0 is legal; the frame is treated as implicitly aligned.
REQ-021 When in_valid=0, slot, state, and out_data SHALL hold, and all pulse outputs SHALL be 0.
REQ-022 in_sof SHALL be ignored when in_valid=0.
REQ-023 At most one bit of out_valid SHALL be high in any cycle.
REQ-024 out_data[k] SHALL hold its last written value until channel k is written again.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear out_data to 0, out_valid to 0, frame_done to 0, sync_err to 0, locked to 0, slot to 0, and state to HUNT, at any point including mid-frame.
REQ-026 The first beat accepted after rst_n deasserts SHALL be sampled on the first rising clk edge with rst_n high, under the HUNT rules.

Structure
REQ-027 A shared package tdm_pkg SHALL hold the state enum (HUNT, LOCKED) and the default constants N_CH_DEF=4 and W_DEF=8.
REQ-028 The slot counter SHALL be a sub-module tdm_slot_counter, with inputs clk, rst_n, inc, and clr_to_one, and output slot.
REQ-029 The channel-write decode SHALL stay in tdm_demux as a single one-hot enable vector.

Verification
REQ-030 Reset, then in_valid with in_sof on 0xA0 and no sof on 0xA1, 0xA2, 0xA3 -> out_data = {A3,A2,A1,A0}, each out_valid pulses 1 cycle after its beat, and frame_done pulses with the 0xA3 beat.
REQ-031 Send 3 beats without sof (0x11, 0x22, 0x33), then sof 0x44 -> no out_valid for the first 3 beats, out_data[0]=0x44, and locked rises.
REQ-032 While locked, sof 0x10, 0x20, then sof 0x30 -> sync_err pulses once, out_data[0]=0x30, the next beat goes to channel 1, and no frame_done fires.
REQ-033 While locked, beats 0x01, 0x02 with 2-cycle in_valid gaps, then 0x03, 0x04 -> slot holds during gaps, all outputs are 0 during gaps, and frame_done pulses on 0x04.
REQ-034 Pulse rst_n low after the channel 1 beat -> outputs are 0 and locked=0 immediately, and a following beat 0x55 without sof is discarded.
REQ-035 With N_CH=3, two consecutive frames -> slot wraps 2 to 0, and frame_done pulses twice, 3 beats apart.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Brief    : Shared types and default constants for the TDM demultiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Default channel count and per-beat data width.
    localparam int N_CH_DEF = 4;
    localparam int W_DEF    = 8;

    // Frame-alignment state: hunting for a start-of-frame, or aligned to one.
    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_counter
//  Brief    : Modulo-N_CH slot counter. Advances on inc, wraps N_CH-1 -> 0,
//             and can be forced to 1 when a start-of-frame beat is taken as
//             slot 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr_to_one,
    output logic [SW-1:0] slot
);

    localparam logic [SW-1:0] c_last = SW'(N_CH - 1);
    localparam logic [SW-1:0] c_one  = SW'(1);

    logic [SW-1:0] r_slot;

    // Slot register: restart at 1 after a start-of-frame beat, else count with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (clr_to_one) begin
            r_slot <= c_one;
        end else if (inc) begin
            r_slot <= (r_slot == c_last) ? '0 : r_slot + c_one;
        end
    end

    assign slot = r_slot;

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Brief    : Time-division demultiplexer. Distributes a serial stream of
//             beats into N_CH per-channel holding registers, aligning on
//             in_sof and flagging misaligned start-of-frame beats.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [W-1:0]             in_data,
    output logic [N_CH-1:0][W-1:0]   out_data,
    output logic [N_CH-1:0]          out_valid,
    output logic                     frame_done,
    output logic                     sync_err,
    output logic                     locked
);

    localparam int            SW     = $clog2(N_CH);
    localparam logic [SW-1:0] c_last = SW'(N_CH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SW-1:0]          w_slot;
    logic                   w_inc;
    logic                   w_clr;
    logic [N_CH-1:0]        w_wr_en;
    logic                   w_frame_done;
    logic                   w_sync_err;

    logic [N_CH-1:0][W-1:0] r_data;
    logic [N_CH-1:0]        r_out_valid;
    logic                   r_frame_done;
    logic                   r_sync_err;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (w_inc),
        .clr_to_one (w_clr),
        .slot       (w_slot)
    );

    // State register; only reset returns the FSM to HUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus one-hot channel-write decode and event flags for this beat.
    always_comb begin
        w_state_nxt  = r_state;
        w_inc        = 1'b0;
        w_clr        = 1'b0;
        w_wr_en      = '0;
        w_frame_done = 1'b0;
        w_sync_err   = 1'b0;
        case (r_state)
            HUNT: begin
                // Non-sof beats are dropped until a start-of-frame is seen.
                if (in_valid && in_sof) begin
                    w_wr_en[0]  = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // sof always realigns to channel 0; only an error if mid-frame.
                        w_wr_en[0] = 1'b1;
                        w_clr      = 1'b1;
                        w_sync_err = (w_slot != '0);
                    end else begin
                        w_wr_en[w_slot] = 1'b1;
                        w_inc           = 1'b1;
                        w_frame_done    = (w_slot == c_last);
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    // Per-channel holding registers, each loaded only by its own enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_wr_en[k]) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    // Pulse outputs: registered alongside the data so they line up with the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_out_valid  <= w_wr_en;
            r_frame_done <= w_frame_done;
            r_sync_err   <= w_sync_err;
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign locked     = (r_state == LOCKED);

endmodule
`default_nettype wire
